tgt_qctx_merge: RTL and testbench
=================================

# tgt_qctx_merge

Parametrised per-queue context store and descriptor/context merge stage on the target P2P path, between the descriptor queue and send processing. It holds one context word per queue, written and read back through the configuration BAR channel. On the first beat of every descriptor packet it snapshots that queue's context and emits a merged stream (context, descriptor, qnum, buffer addresses) through a registered skid buffer. Packets for disabled queues (context bit 0 clear) are dropped, reported, and counted.

## Interface
- NQ, 16, number of queues (2..64)
- QNUM_W, 4, queue index width, ≥ clog2(NQ)
- CTX_W, 64, context word width; bit 0 = queue enable
- DESC_W, 64, descriptor width
- BUF_AW, 16, buffer address width
- CFG_BASE, 20'h01000, byte offset of entry 0 within the cfg BAR
- STRIDE_LOG, 4, log2 byte stride between entries
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wr_valid  in  1  context write
- cfg_wr_addr  in  32  BAR byte address
- cfg_wr_data  in  CTX_W  write data
- cfg_wr_ready  out  1  constant 1
- cfg_rd_valid  in  1  context read request
- cfg_rd_addr  in  32  BAR byte address
- cfg_rd_ready  out  1  read request accepted
- cfg_rrsp_valid  out  1  read response
- cfg_rrsp_data  out  CTX_W  read data
- cfg_rrsp_ready  in  1  response accepted
- in_valid / in_last / in_ready  in / in / out  1  descriptor stream handshake
- in_desc  in  DESC_W  descriptor, meaningful on first beat
- in_qnum  in  QNUM_W  queue number, meaningful on first beat
- in_buf_addr  in  BUF_AW  one buffer address per beat
- out_valid / out_last / out_ready  out / out / in  1  merged stream handshake
- out_ctx  out  CTX_W  context snapshot, constant across a packet
- out_desc / out_qnum / out_buf_addr  out  DESC_W / QNUM_W / BUF_AW  forwarded fields
- drop_wen  out  1  one-cycle pulse per dropped packet
- drop_qnum  out  QNUM_W  queue of the dropped packet
- drop_cnt  out  32  saturating count of dropped packets

## Operation
- Decode: off = addr[19:0] − CFG_BASE (20-bit); idx = off >> STRIDE_LOG. An address is in range iff off < NQ<<STRIDE_LOG. Out-of-range writes are ignored. Out-of-range reads return 0.
- Context store: NQ×CTX_W flop array; reset value 0, so every queue is disabled.
- Packet: consecutive accepted in-beats up to and including in_last. An internal sop flag resets to 1, clears on a non-last accepted beat, and sets on an accepted last beat.
- On the sop beat: ctx_snap ← ctx[in_qnum] (combinational read); desc/qnum are latched for the whole packet.
- Same-cycle cfg write to that qnum: the snapshot takes the old value. The write lands at the clock edge.
- in_qnum ≥ NQ: treated as disabled.
- Pass mode (ctx_snap[0]=1): each beat enters the 2-entry skid buffer. in_ready = skid not full.
- Drop mode (ctx_snap[0]=0):
  - in_ready=1 for the whole packet, and beats are discarded.
  - drop_wen=1 and drop_qnum=in_qnum in the cycle after sop acceptance.
  - drop_cnt increments, saturating at 2^32−1.
- Readback: cfg_rd_ready = !cfg_rrsp_valid | cfg_rrsp_ready. The response registers the next cycle and holds stable until cfg_rrsp_ready.

## Timing
- Reset values: out_valid=0, out_last=0, all out data fields 0, cfg_rrsp_valid=0, cfg_rrsp_data=0, drop_wen=0, drop_qnum=0, drop_cnt=0, sop=1.
- Latency: in accept at cycle N gives out_valid at N+1 when the skid buffer is empty.
- Throughput is 1 beat/cycle with out_ready held high.
- The out stream obeys valid/ready: once asserted, out_valid and all out fields hold until accepted.
- out_ready low: the skid buffer absorbs one more beat, then in_ready drops in the following cycle.
- Readback latency is 1 cycle; back-to-back reads achieve 1/cycle with cfg_rrsp_ready high.
- Reset mid-packet: the skid buffer is flushed, sop=1, and the partial packet is lost. Upstream must also reset.
- Writes are never back-pressured. A write and a read to the same idx in the same cycle return the old value.

## Structure
- Shared package (team `define header): CTX_EN_BIT, CFG_BASE and STRIDE_LOG defaults, and the in/out beat bundle layout {last, desc, qnum, buf_addr, ctx}.
- Sub-module: tgt_skid2, a generic 2-entry valid/ready skid buffer parametrised by payload width. It is reusable on other P2P output stages.
- The remaining logic (decode, context array, sop/mode FSM, drop counter, readback register) lives in the top-level block.

## Test plan
- Write ctx[3]=64'h…0001 at addr CFG_BASE+0x30, then send a 3-beat packet with qnum 3 and buf 0x10/0x11/0x12 -> 3 out beats at N+1..N+3; out_ctx=…0001 on all beats; out_last only on the 3rd beat; drop_wen never asserts.
- Send a packet on qnum 5 with no context written -> in_ready stays 1; no out_valid; drop_wen pulses once with drop_qnum=5; drop_cnt=1.
- Write ctx[3] in the same cycle as qnum-3 sop acceptance -> the packet uses the old ctx; the next packet uses the new ctx.
- Hold out_ready=0 during a 4-beat pass packet -> exactly 2 beats buffered; in_ready=0 from the 3rd cycle; all 4 beats delivered in order with no duplicates after release.
- Read addr CFG_BASE+0x30 with cfg_rrsp_ready=0 for 3 cycles -> data stable and cfg_rd_ready=0 until accepted. Read CFG_BASE+NQ·16 -> data 0.
- Assert rst_n low mid-packet -> all outputs return to reset values; a fresh packet afterwards passes normally once its ctx is rewritten.

Source files
------------

// File: rtl/tgt_qctx_merge_pkg.sv
// Shared definitions for the target P2P context merge stage: defaults, the
// packet-mode enum and the merged beat bundle width.
package tgt_qctx_merge_pkg;

   localparam int          CTX_EN_BIT     = 0;
   localparam logic [19:0] CFG_BASE_DEF   = 20'h01000;
   localparam int          STRIDE_LOG_DEF = 4;

   typedef enum logic [1:0] {
      ST_SOP  = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } mode_e;

   // The beat bundle is packed MSB..LSB as {last, desc, qnum, buf_addr, ctx}.
   function automatic int beat_w(input int desc_w, input int qnum_w,
                                 input int buf_aw, input int ctx_w);
      return 1 + desc_w + qnum_w + buf_aw + ctx_w;
   endfunction

endpackage

// File: rtl/tgt_skid2.sv
// Generic 2-entry valid/ready skid buffer with a fully registered output side.
module tgt_skid2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         skid_v;
   logic [W-1:0] skid_d;
   logic         pop;

   assign in_ready = !skid_v;
   assign pop      = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_v    <= 1'b0;
         skid_d    <= '0;
      end else if (pop) begin
         // The held beat always drains ahead of anything new to keep order.
         if (skid_v) begin
            out_valid <= 1'b1;
            out_data  <= skid_d;
            skid_v    <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end else if (in_valid && !skid_v) begin
         skid_v <= 1'b1;
         skid_d <= in_data;
      end
   end

endmodule

// File: rtl/tgt_qctx_merge.sv
// Per-queue context store plus descriptor/context merge with drop of disabled queues.
//   state   | meaning
//   ST_SOP  | waiting for the first beat of a packet; mode decided from ctx[in_qnum]
//   ST_PASS | mid-packet, beats forwarded into the skid buffer
//   ST_DROP | mid-packet, beats accepted and discarded
module tgt_qctx_merge
   import tgt_qctx_merge_pkg::*;
#(
   parameter int          NQ         = 16,
   parameter int          QNUM_W     = 4,
   parameter int          CTX_W      = 64,
   parameter int          DESC_W     = 64,
   parameter int          BUF_AW     = 16,
   parameter logic [19:0] CFG_BASE   = CFG_BASE_DEF,
   parameter int          STRIDE_LOG = STRIDE_LOG_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_wr_valid,
   input  logic [31:0]       cfg_wr_addr,
   input  logic [CTX_W-1:0]  cfg_wr_data,
   output logic              cfg_wr_ready,
   input  logic              cfg_rd_valid,
   input  logic [31:0]       cfg_rd_addr,
   output logic              cfg_rd_ready,
   output logic              cfg_rrsp_valid,
   output logic [CTX_W-1:0]  cfg_rrsp_data,
   input  logic              cfg_rrsp_ready,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [DESC_W-1:0] in_desc,
   input  logic [QNUM_W-1:0] in_qnum,
   input  logic [BUF_AW-1:0] in_buf_addr,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic [CTX_W-1:0]  out_ctx,
   output logic [DESC_W-1:0] out_desc,
   output logic [QNUM_W-1:0] out_qnum,
   output logic [BUF_AW-1:0] out_buf_addr,
   output logic              drop_wen,
   output logic [QNUM_W-1:0] drop_qnum,
   output logic [31:0]       drop_cnt
);

   localparam int          BW   = beat_w(DESC_W, QNUM_W, BUF_AW, CTX_W);
   localparam logic [19:0] SPAN = 20'(NQ << STRIDE_LOG);

   logic [CTX_W-1:0]  ctx_q [NQ];
   logic [19:0]       wr_off, rd_off, wr_sh, rd_sh;
   logic              wr_hit, rd_hit;
   logic [QNUM_W-1:0] wr_idx, rd_idx;
   logic [CTX_W-1:0]  rd_data, sop_ctx;

   mode_e             state_q, state_d;
   logic              sop, cur_drop, in_fire;
   logic [CTX_W-1:0]  snap_ctx;
   logic [DESC_W-1:0] snap_desc;
   logic [QNUM_W-1:0] snap_qnum;
   logic              skid_in_ready;
   logic [BW-1:0]     beat_in, beat_out;

   assign wr_off = cfg_wr_addr[19:0] - CFG_BASE;
   assign rd_off = cfg_rd_addr[19:0] - CFG_BASE;
   assign wr_sh  = wr_off >> STRIDE_LOG;
   assign rd_sh  = rd_off >> STRIDE_LOG;
   assign wr_hit = wr_off < SPAN;
   assign rd_hit = rd_off < SPAN;
   assign wr_idx = wr_sh[QNUM_W-1:0];
   assign rd_idx = rd_sh[QNUM_W-1:0];

   assign cfg_wr_ready = 1'b1;
   assign cfg_rd_ready = !cfg_rrsp_valid || cfg_rrsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NQ; i++) ctx_q[i] <= '0;
      end else if (cfg_wr_valid && wr_hit) begin
         for (int i = 0; i < NQ; i++)
            if (wr_idx == QNUM_W'(i)) ctx_q[i] <= cfg_wr_data;
      end
   end

   // Queue numbers at or beyond NQ fall through to zero, i.e. disabled.
   always_comb begin
      rd_data = '0;
      sop_ctx = '0;
      for (int i = 0; i < NQ; i++) begin
         if (rd_hit && rd_idx == QNUM_W'(i)) rd_data = ctx_q[i];
         if (in_qnum == QNUM_W'(i))          sop_ctx = ctx_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_rrsp_valid <= 1'b0;
         cfg_rrsp_data  <= '0;
      end else if (cfg_rd_valid && cfg_rd_ready) begin
         cfg_rrsp_valid <= 1'b1;
         cfg_rrsp_data  <= rd_data;
      end else if (cfg_rrsp_ready) begin
         cfg_rrsp_valid <= 1'b0;
      end
   end

   assign sop = (state_q == ST_SOP);

   always_comb begin
      state_d  = state_q;
      cur_drop = 1'b1;
      case (state_q)
         ST_SOP:  cur_drop = !sop_ctx[CTX_EN_BIT];
         ST_PASS: cur_drop = 1'b0;
         ST_DROP: cur_drop = 1'b1;
         default: cur_drop = 1'b1;
      endcase
      in_ready = cur_drop || skid_in_ready;
      in_fire  = in_valid && in_ready;
      if (in_fire) state_d = in_last ? ST_SOP : (cur_drop ? ST_DROP : ST_PASS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SOP;
         snap_ctx  <= '0;
         snap_desc <= '0;
         snap_qnum <= '0;
         drop_wen  <= 1'b0;
         drop_qnum <= '0;
         drop_cnt  <= '0;
      end else begin
         state_q  <= state_d;
         drop_wen <= in_fire && sop && cur_drop;
         if (in_fire && sop) begin
            snap_ctx  <= sop_ctx;
            snap_desc <= in_desc;
            snap_qnum <= in_qnum;
         end
         if (in_fire && sop && cur_drop) begin
            drop_qnum <= in_qnum;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
         end
      end
   end

   assign beat_in = sop ? {in_last, in_desc, in_qnum, in_buf_addr, sop_ctx}
                        : {in_last, snap_desc, snap_qnum, in_buf_addr, snap_ctx};

   tgt_skid2 #(.W(BW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid && !cur_drop),
      .in_ready  (skid_in_ready),
      .in_data   (beat_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (beat_out)
   );

   assign {out_last, out_desc, out_qnum, out_buf_addr, out_ctx} = beat_out;

   logic unused_ok;
   assign unused_ok = ^{cfg_wr_addr[31:20], cfg_rd_addr[31:20],
                        wr_sh[19:QNUM_W], rd_sh[19:QNUM_W]};

endmodule

// File: tb/tb_tgt_qctx_merge.sv
// Self-checking bench for tgt_qctx_merge: cfg vector table, packet scoreboard,
// and hand-written sequences for back-pressure, same-cycle write and reset.
module tb_tgt_qctx_merge;

   localparam int NQ = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_wr_valid, cfg_rd_valid, cfg_rrsp_ready;
   logic [31:0] cfg_wr_addr, cfg_rd_addr;
   logic [63:0] cfg_wr_data, cfg_rrsp_data;
   logic        cfg_wr_ready, cfg_rd_ready, cfg_rrsp_valid;
   logic        in_valid, in_last, in_ready;
   logic [63:0] in_desc;
   logic [3:0]  in_qnum;
   logic [15:0] in_buf_addr;
   logic        out_valid, out_last, out_ready;
   logic [63:0] out_ctx, out_desc;
   logic [3:0]  out_qnum;
   logic [15:0] out_buf_addr;
   logic        drop_wen;
   logic [3:0]  drop_qnum;
   logic [31:0] drop_cnt;

   always #5 clk = ~clk;

   tgt_qctx_merge #(
      .NQ(16), .QNUM_W(4), .CTX_W(64), .DESC_W(64), .BUF_AW(16),
      .CFG_BASE(20'h01000), .STRIDE_LOG(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_wr_valid(cfg_wr_valid), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
      .cfg_wr_ready(cfg_wr_ready),
      .cfg_rd_valid(cfg_rd_valid), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_ready(cfg_rd_ready),
      .cfg_rrsp_valid(cfg_rrsp_valid), .cfg_rrsp_data(cfg_rrsp_data),
      .cfg_rrsp_ready(cfg_rrsp_ready),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .in_desc(in_desc), .in_qnum(in_qnum), .in_buf_addr(in_buf_addr),
      .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .out_ctx(out_ctx), .out_desc(out_desc), .out_qnum(out_qnum),
      .out_buf_addr(out_buf_addr),
      .drop_wen(drop_wen), .drop_qnum(drop_qnum), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [63:0] ctx;
      logic [63:0] desc;
      logic [3:0]  qnum;
      logic [15:0] baddr;
      logic        last;
   } beat_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [63:0] data;
      int          q;
      logic [63:0] exp;
   } cfg_vec_t;

   beat_t       exp_q[$];
   logic [63:0] rd_exp_q[$];
   logic [3:0]  drop_exp_q[$];
   beat_t       mon_e;
   logic [63:0] mon_rd;
   logic [3:0]  mon_dq;

   logic [63:0] ctx_m [NQ];
   bit          m_sop;
   bit          m_pass;
   logic [63:0] m_ctx, m_desc;
   logic [3:0]  m_q;
   int          m_drops;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] NEW3 = 64'hA5A5_0000_0000_0003;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("out_unexpected_beat");
            else begin
               mon_e = exp_q.pop_front();
               chk("out_ctx", out_ctx, mon_e.ctx);
               chk("out_desc", out_desc, mon_e.desc);
               chk("out_qnum", 64'(out_qnum), 64'(mon_e.qnum));
               chk("out_buf_addr", 64'(out_buf_addr), 64'(mon_e.baddr));
               chk("out_last", 64'(out_last), 64'(mon_e.last));
            end
         end
         if (cfg_rrsp_valid && cfg_rrsp_ready) begin
            if (rd_exp_q.size() == 0) fail_now("rrsp_unexpected");
            else begin
               mon_rd = rd_exp_q.pop_front();
               chk("rrsp_data", cfg_rrsp_data, mon_rd);
            end
         end
         if (drop_wen) begin
            if (drop_exp_q.size() == 0) fail_now("drop_unexpected");
            else begin
               mon_dq = drop_exp_q.pop_front();
               chk("drop_qnum", 64'(drop_qnum), 64'(mon_dq));
            end
         end
      end
   end

   // Reference model of packet acceptance, evaluated at the accepting edge.
   task automatic model_accept();
      if (m_sop) begin
         m_ctx  = ctx_m[in_qnum];
         m_pass = m_ctx[0];
         m_desc = in_desc;
         m_q    = in_qnum;
         if (!m_pass) begin
            drop_exp_q.push_back(in_qnum);
            m_drops++;
         end
      end
      if (m_pass)
         exp_q.push_back('{ctx: m_ctx, desc: m_desc, qnum: m_q, baddr: in_buf_addr, last: in_last});
      m_sop = in_last;
   endtask

   task automatic present(input logic [3:0] q, input logic [63:0] d,
                          input logic [15:0] b, input logic l);
      in_valid    = 1'b1;
      in_qnum     = q;
      in_desc     = d;
      in_buf_addr = b;
      in_last     = l;
   endtask

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("in_accept_timeout");
      else model_accept();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [3:0] q, input logic [63:0] d,
                           input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         present(q, d, base + 16'(i), (i == n - 1));
         wait_accept();
      end
      in_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [31:0] a, input logic [63:0] d);
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = a;
      cfg_wr_data  = d;
      @(posedge clk);
      #1;
      cfg_wr_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && rd_exp_q.size() == 0 && drop_exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   cfg_vec_t tbl[15];

   initial begin
      tbl[0]  = '{1'b1, 32'h0000_1030, 64'h0000_0000_0000_0001, 3,  64'h0};
      tbl[1]  = '{1'b1, 32'h0000_1000, 64'hDEAD_BEEF_0000_0000, 0,  64'h0};
      tbl[2]  = '{1'b1, 32'h0000_10F0, 64'h0123_4567_89AB_CDEF, 15, 64'h0};
      tbl[3]  = '{1'b1, 32'h0000_1100, 64'hFFFF_FFFF_FFFF_FFFF, -1, 64'h0};
      tbl[4]  = '{1'b1, 32'h0000_0FF0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 64'h0};
      tbl[5]  = '{1'b1, 32'hABC0_1070, 64'h0000_0000_0000_0077, 7,  64'h0};
      tbl[6]  = '{1'b1, 32'h0000_1088, 64'h8000_0000_0000_0000, 8,  64'h0};
      tbl[7]  = '{1'b0, 32'h0000_1030, 64'h0, -1, 64'h0000_0000_0000_0001};
      tbl[8]  = '{1'b0, 32'h0000_1000, 64'h0, -1, 64'hDEAD_BEEF_0000_0000};
      tbl[9]  = '{1'b0, 32'h0000_10F0, 64'h0, -1, 64'h0123_4567_89AB_CDEF};
      tbl[10] = '{1'b0, 32'h0000_1100, 64'h0, -1, 64'h0};
      tbl[11] = '{1'b0, 32'h0000_0FF0, 64'h0, -1, 64'h0};
      tbl[12] = '{1'b0, 32'h0000_1070, 64'h0, -1, 64'h0000_0000_0000_0077};
      tbl[13] = '{1'b0, 32'h0000_108C, 64'h0, -1, 64'h8000_0000_0000_0000};
      tbl[14] = '{1'b0, 32'h0000_1050, 64'h0, -1, 64'h0};

      for (int i = 0; i < NQ; i++) ctx_m[i] = '0;
      m_sop = 1'b1; m_pass = 1'b0; m_drops = 0;
      m_ctx = '0; m_desc = '0; m_q = '0;
      rst_n = 1'b0;
      cfg_wr_valid = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
      cfg_rd_valid = 1'b0; cfg_rd_addr = '0; cfg_rrsp_ready = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; in_desc = '0; in_qnum = '0; in_buf_addr = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_ctx", out_ctx, 64'd0);
      chk("rst_out_desc", out_desc, 64'd0);
      chk("rst_out_buf", 64'(out_buf_addr), 64'd0);
      chk("rst_rrsp_valid", 64'(cfg_rrsp_valid), 64'd0);
      chk("rst_rrsp_data", cfg_rrsp_data, 64'd0);
      chk("rst_drop_wen", 64'(drop_wen), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("cfg_wr_ready", 64'(cfg_wr_ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Context programming and readback, back-to-back reads.
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].wr) begin
            cfg_write(tbl[i].addr, tbl[i].data);
            if (tbl[i].q >= 0) ctx_m[tbl[i].q] = tbl[i].data;
         end else begin
            cfg_rd_valid = 1'b1;
            cfg_rd_addr  = tbl[i].addr;
            @(negedge clk);
            chk("rd_ready_b2b", 64'(cfg_rd_ready), 64'd1);
            if (cfg_rd_ready) rd_exp_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
         end
      end
      cfg_rd_valid = 1'b0;
      drain();

      // Pass packet on qnum 3: each beat visible one cycle after acceptance.
      for (int i = 0; i < 3; i++) begin
         present(4'd3, 64'h1111_2222_3333_4444, 16'h0010 + 16'(i), (i == 2));
         wait_accept();
         chk("lat_out_valid", 64'(out_valid), 64'd1);
         chk("lat_out_buf", 64'(out_buf_addr), 64'h0010 + 64'(i));
      end
      in_valid = 1'b0;
      drain();

      // Drop packet on unwritten qnum 5.
      for (int i = 0; i < 3; i++) begin
         present(4'd5, 64'h5555_0000_0000_0005, 16'h0020 + 16'(i), (i == 2));
         wait_accept();
         if (i == 0) begin
            chk("drop_wen_pulse", 64'(drop_wen), 64'd1);
            chk("drop_qnum_5", 64'(drop_qnum), 64'd5);
         end
      end
      in_valid = 1'b0;
      drain();
      chk("drop_cnt_1", 64'(drop_cnt), 64'(m_drops));

      // Same-cycle cfg write to the sop queue: snapshot keeps the old value.
      present(4'd3, 64'h3333_0000_0000_0001, 16'h0030, 1'b1);
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = 32'h0000_1030;
      cfg_wr_data  = NEW3;
      wait_accept();
      cfg_wr_valid = 1'b0;
      ctx_m[3] = NEW3;
      in_valid = 1'b0;
      chk("same_cycle_old_ctx", out_ctx, 64'h0000_0000_0000_0001);
      send_pkt(4'd3, 64'h3333_0000_0000_0002, 2, 16'h0031);
      drain();

      // Back-pressure: two beats absorbed, third stalls until release.
      out_ready = 1'b0;
      present(4'd3, 64'h4444_0000_0000_0004, 16'h0040, 1'b0);
      wait_accept();
      present(4'd3, 64'h4444_0000_0000_0004, 16'h0041, 1'b0);
      wait_accept();
      present(4'd3, 64'h4444_0000_0000_0004, 16'h0042, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
         chk("bp_out_valid_hold", 64'(out_valid), 64'd1);
         chk("bp_out_buf_hold", 64'(out_buf_addr), 64'h0040);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_accept();
      present(4'd3, 64'h4444_0000_0000_0004, 16'h0043, 1'b1);
      wait_accept();
      in_valid = 1'b0;
      drain();

      // Read response held while cfg_rrsp_ready is low.
      cfg_rrsp_ready = 1'b0;
      cfg_rd_valid   = 1'b1;
      cfg_rd_addr    = 32'h0000_1030;
      @(negedge clk);
      chk("stall_rd_ready_first", 64'(cfg_rd_ready), 64'd1);
      if (cfg_rd_ready) rd_exp_q.push_back(ctx_m[3]);
      @(posedge clk);
      #1;
      cfg_rd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_rrsp_valid", 64'(cfg_rrsp_valid), 64'd1);
         chk("stall_rrsp_data", cfg_rrsp_data, NEW3);
         chk("stall_rd_ready_low", 64'(cfg_rd_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      cfg_rrsp_ready = 1'b1;
      drain();

      // Reset in the middle of a packet with beats sitting in the skid buffer.
      out_ready = 1'b0;
      present(4'd3, 64'h6666_0000_0000_0006, 16'h0050, 1'b0);
      wait_accept();
      present(4'd3, 64'h6666_0000_0000_0006, 16'h0051, 1'b0);
      wait_accept();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_out_last", 64'(out_last), 64'd0);
      chk("mrst_out_ctx", out_ctx, 64'd0);
      chk("mrst_out_buf", 64'(out_buf_addr), 64'd0);
      chk("mrst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("mrst_rrsp_valid", 64'(cfg_rrsp_valid), 64'd0);
      exp_q.delete();
      drop_exp_q.delete();
      rd_exp_q.delete();
      for (int i = 0; i < NQ; i++) ctx_m[i] = '0;
      m_sop = 1'b1; m_pass = 1'b0; m_drops = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send_pkt(4'd3, 64'h7777_0000_0000_0007, 2, 16'h0058);
      drain();
      cfg_write(32'h0000_1030, 64'h0000_0000_0000_0001);
      ctx_m[3] = 64'h0000_0000_0000_0001;
      send_pkt(4'd3, 64'h7777_0000_0000_0008, 2, 16'h0060);
      drain();
      chk("post_rst_drop_cnt", 64'(drop_cnt), 64'(m_drops));
      chk("end_out_q_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
